// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment bit order: {dp, g, f, e, d, c, b, a}, active-high.
package seg_scan_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] DATA_0    = 8'h3F;
    localparam logic [7:0] DATA_1    = 8'h06;
    localparam logic [7:0] DATA_2    = 8'h5B;
    localparam logic [7:0] DATA_3    = 8'h4F;
    localparam logic [7:0] DATA_4    = 8'h66;
    localparam logic [7:0] DATA_5    = 8'h6D;
    localparam logic [7:0] DATA_6    = 8'h7D;
    localparam logic [7:0] DATA_7    = 8'h07;
    localparam logic [7:0] DATA_8    = 8'h7F;
    localparam logic [7:0] DATA_9    = 8'h6F;
    localparam logic [7:0] DATA_A    = 8'h77;
    localparam logic [7:0] DATA_B    = 8'h7C;
    localparam logic [7:0] DATA_C    = 8'h39;
    localparam logic [7:0] DATA_D    = 8'h5E;
    localparam logic [7:0] DATA_E    = 8'h79;
    localparam logic [7:0] DATA_F    = 8'h71;

    localparam int DIG_PC_HI  = 0;
    localparam int DIG_KEY_HI = 4;
    localparam int DIG_RES_HI = 6;

    typedef enum logic [1:0] {
        W_PC   = 2'd0,
        W_KEY  = 2'd1,
        W_RES  = 2'd2,
        W_NONE = 2'd3
    } writer_e;

    function automatic writer_e rr_succ(input writer_e w);
        case (w)
            W_PC:    return W_KEY;
            W_KEY:   return W_RES;
            default: return W_PC;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (hex_i)
            4'h0: seg_o = DATA_0;
            4'h1: seg_o = DATA_1;
            4'h2: seg_o = DATA_2;
            4'h3: seg_o = DATA_3;
            4'h4: seg_o = DATA_4;
            4'h5: seg_o = DATA_5;
            4'h6: seg_o = DATA_6;
            4'h7: seg_o = DATA_7;
            4'h8: seg_o = DATA_8;
            4'h9: seg_o = DATA_9;
            4'hA: seg_o = DATA_A;
            4'hB: seg_o = DATA_B;
            4'hC: seg_o = DATA_C;
            4'hD: seg_o = DATA_D;
            4'hE: seg_o = DATA_E;
            4'hF: seg_o = DATA_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with a three-writer
// round-robin arbiter feeding a nibble display buffer.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 2500,
    parameter int unsigned BLANK_CYC = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       pc_req,
    input  logic [7:0] pc_data,
    output logic       pc_gnt,
    input  logic       key_req,
    input  logic [7:0] key_data,
    output logic       key_gnt,
    input  logic       res_req,
    input  logic [7:0] res_data,
    output logic       res_gnt,
    output logic [2:0] sel,
    output logic [7:0] seg
);

    localparam int unsigned CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);

    logic [2:0]      req_v;
    logic [2:0]      gnt_q, gnt_d;
    writer_e         ptr_q, ptr_d, win;
    logic [7:0][3:0] dbuf_q, dbuf_d;
    logic [CW-1:0]   slot_q, slot_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      seg_q, seg_d;
    logic [7:0]      hex_seg;

    // A writer whose grant is still high sits out this round.
    assign req_v = {res_req, key_req, pc_req} & ~gnt_q;

    always_comb begin
        win = W_NONE;
        case (ptr_q)
            W_PC: begin
                if (req_v[0])      win = W_PC;
                else if (req_v[1]) win = W_KEY;
                else if (req_v[2]) win = W_RES;
            end
            W_KEY: begin
                if (req_v[1])      win = W_KEY;
                else if (req_v[2]) win = W_RES;
                else if (req_v[0]) win = W_PC;
            end
            default: begin
                if (req_v[2])      win = W_RES;
                else if (req_v[0]) win = W_PC;
                else if (req_v[1]) win = W_KEY;
            end
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        dbuf_d = dbuf_q;
        ptr_d  = (win == W_NONE) ? ptr_q : rr_succ(win);
        case (win)
            W_PC: begin
                gnt_d[0]               = 1'b1;
                dbuf_d[DIG_PC_HI]      = pc_data[7:4];
                dbuf_d[DIG_PC_HI + 1]  = pc_data[3:0];
            end
            W_KEY: begin
                gnt_d[1]               = 1'b1;
                dbuf_d[DIG_KEY_HI]     = key_data[7:4];
                dbuf_d[DIG_KEY_HI + 1] = key_data[3:0];
            end
            W_RES: begin
                gnt_d[2]               = 1'b1;
                dbuf_d[DIG_RES_HI]     = res_data[7:4];
                dbuf_d[DIG_RES_HI + 1] = res_data[3:0];
            end
            default: ;
        endcase
    end

    hex_to_seg u_hex (
        .hex_i (dbuf_q[sel_q]),
        .seg_o (hex_seg)
    );

    always_comb begin
        slot_d = slot_q;
        sel_d  = sel_q;
        if (scan_en) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                sel_d  = sel_q + 3'd1;
            end else begin
                slot_d = slot_q + CW'(1);
            end
        end
        seg_d = hex_seg;
        if (!scan_en || (32'(slot_q) < BLANK_CYC))
            seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            gnt_q  <= '0;
            ptr_q  <= W_PC;
            dbuf_q <= '0;
            slot_q <= '0;
            sel_q  <= '0;
            seg_q  <= SEG_BLANK;
        end else begin
            gnt_q  <= gnt_d;
            ptr_q  <= ptr_d;
            dbuf_q <= dbuf_d;
            slot_q <= slot_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign pc_gnt  = gnt_q[0];
    assign key_gnt = gnt_q[1];
    assign res_gnt = gnt_q[2];
    assign sel     = sel_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b1;
    logic       pc_req = 1'b0, key_req = 1'b0, res_req = 1'b0;
    logic [7:0] pc_data = '0, key_data = '0, res_data = '0;
    logic       pc_gnt, key_gnt, res_gnt;
    logic [2:0] sel;
    logic [7:0] seg;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .pc_req   (pc_req),
        .pc_data  (pc_data),
        .pc_gnt   (pc_gnt),
        .key_req  (key_req),
        .key_data (key_data),
        .key_gnt  (key_gnt),
        .res_req  (res_req),
        .res_data (res_data),
        .res_gnt  (res_gnt),
        .sel      (sel),
        .seg      (seg)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1ns after the last reset edge: cycle k=0.
    task automatic do_reset();
        rst = 1'b1;
        pc_req = 1'b0; key_req = 1'b0; res_req = 1'b0;
        scan_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({sel, seg, res_gnt, key_gnt, pc_gnt} !== 14'h0) begin
            nerr++;
            $display("FAIL reset_state got sel=%0d seg=%h gnt=%b exp 0/00/000",
                     sel, seg, {res_gnt, key_gnt, pc_gnt});
        end
        step(11);
        nvec++;
        if (seg !== 8'h3F || sel !== 3'd1) begin
            nerr++;
            $display("FAIL pre_reset got sel=%0d seg=%h exp 1/3f", sel, seg);
        end
        #3 rst = 1'b1;
        #1;
        nvec++;
        if (sel !== 3'd0 || seg !== 8'h00) begin
            nerr++;
            $display("FAIL async_reset got sel=%0d seg=%h exp 0/00", sel, seg);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pc_req = 1'b1; pc_data = 8'hA5;
        step(1);
        nvec++;
        if (pc_gnt !== 1'b1) begin
            nerr++;
            $display("FAIL grant_before_reset got %b exp 1", pc_gnt);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({res_gnt, key_gnt, pc_gnt} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_mid_grant got %b exp 000", {res_gnt, key_gnt, pc_gnt});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        nvec++;
        if (pc_gnt !== 1'b1) begin
            nerr++;
            $display("FAIL regrant_after_reset got %b exp 1", pc_gnt);
        end
        pc_req = 1'b0;
    endtask

    task automatic test_scan();
        logic [2:0] es;
        logic [7:0] eg;
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            step(1);
            es = 3'((k / 8) % 8);
            eg = (((k - 1) % 8) < 2) ? 8'h00 : 8'h3F;
            nvec++;
            if (sel !== es) begin
                nerr++;
                $display("FAIL scan_sel k=%0d got %0d exp %0d", k, sel, es);
            end
            nvec++;
            if (seg !== eg) begin
                nerr++;
                $display("FAIL scan_seg k=%0d got %h exp %h", k, seg, eg);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        pc_req = 1'b1; pc_data = 8'h3A;
        step(1);
        nvec++;
        if (pc_gnt !== 1'b1) begin
            nerr++;
            $display("FAIL single_gnt_hi got %b exp 1", pc_gnt);
        end
        pc_req = 1'b0;
        step(1);
        nvec++;
        if (pc_gnt !== 1'b0 || seg !== 8'h00) begin
            nerr++;
            $display("FAIL single_gnt_lo got gnt=%b seg=%h exp 0/00", pc_gnt, seg);
        end
        step(1);
        nvec++;
        if (seg !== 8'h4F) begin
            nerr++;
            $display("FAIL single_dig0 got %h exp 4f", seg);
        end
        step(8);
        nvec++;
        if (sel !== 3'd1 || seg !== 8'h77) begin
            nerr++;
            $display("FAIL single_dig1 got sel=%0d seg=%h exp 1/77", sel, seg);
        end
        step(8);
        nvec++;
        if (sel !== 3'd2 || seg !== 8'h3F) begin
            nerr++;
            $display("FAIL single_dig2 got sel=%0d seg=%h exp 2/3f", sel, seg);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        pc_req = 1'b1;  pc_data = 8'h12;
        key_req = 1'b1; key_data = 8'h34;
        res_req = 1'b1; res_data = 8'h56;
        for (int i = 0; i < 6; i++) begin
            step(1);
            nvec++;
            if ({res_gnt, key_gnt, pc_gnt} !== exp_g[i]) begin
                nerr++;
                $display("FAIL contention cyc=%0d got %b exp %b",
                         i + 1, {res_gnt, key_gnt, pc_gnt}, exp_g[i]);
            end
        end
        pc_req = 1'b0; key_req = 1'b0; res_req = 1'b0;
        step(1);
        nvec++;
        if ({res_gnt, key_gnt, pc_gnt} !== 3'b000) begin
            nerr++;
            $display("FAIL contention_idle got %b exp 000", {res_gnt, key_gnt, pc_gnt});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_p = 4'b0101;
        do_reset();
        pc_req = 1'b1; pc_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step(1);
            nvec++;
            if (pc_gnt !== exp_p[i] || key_gnt !== 1'b0 || res_gnt !== 1'b0) begin
                nerr++;
                $display("FAIL back_to_back cyc=%0d got %b exp %b",
                         i + 1, {res_gnt, key_gnt, pc_gnt}, {2'b00, exp_p[i]});
            end
        end
        pc_req = 1'b0;
    endtask

    task automatic test_scan_en();
        do_reset();
        step(11);
        scan_en = 1'b0;
        res_req = 1'b1; res_data = 8'h9C;
        step(1);
        nvec++;
        if (res_gnt !== 1'b1 || seg !== 8'h00 || sel !== 3'd1) begin
            nerr++;
            $display("FAIL scan_off_gnt got gnt=%b seg=%h sel=%0d exp 1/00/1",
                     res_gnt, seg, sel);
        end
        res_req = 1'b0;
        for (int k = 13; k <= 31; k++) begin
            step(1);
            if (k % 6 == 0) begin
                nvec++;
                if (seg !== 8'h00 || sel !== 3'd1) begin
                    nerr++;
                    $display("FAIL scan_frozen k=%0d got seg=%h sel=%0d exp 00/1",
                             k, seg, sel);
                end
            end
        end
        scan_en = 1'b1;
        step(1);
        nvec++;
        if (seg !== 8'h3F || sel !== 3'd1) begin
            nerr++;
            $display("FAIL scan_resume got seg=%h sel=%0d exp 3f/1", seg, sel);
        end
        step(37);
        nvec++;
        if (seg !== 8'h00 || sel !== 3'd6) begin
            nerr++;
            $display("FAIL scan_dig6_blank got seg=%h sel=%0d exp 00/6", seg, sel);
        end
        step(2);
        nvec++;
        if (seg !== 8'h6F || sel !== 3'd6) begin
            nerr++;
            $display("FAIL scan_dig6 got seg=%h sel=%0d exp 6f/6", seg, sel);
        end
        step(8);
        nvec++;
        if (seg !== 8'h39 || sel !== 3'd7) begin
            nerr++;
            $display("FAIL scan_dig7 got seg=%h sel=%0d exp 39/7", seg, sel);
        end
    endtask

    task automatic test_live_update();
        do_reset();
        step(35);
        key_req = 1'b1; key_data = 8'h5F;
        step(1);
        nvec++;
        if (key_gnt !== 1'b1 || seg !== 8'h3F || sel !== 3'd4) begin
            nerr++;
            $display("FAIL live_write_edge got gnt=%b seg=%h sel=%0d exp 1/3f/4",
                     key_gnt, seg, sel);
        end
        key_req = 1'b0;
        step(1);
        nvec++;
        if (seg !== 8'h6D || sel !== 3'd4) begin
            nerr++;
            $display("FAIL live_update got seg=%h sel=%0d exp 6d/4", seg, sel);
        end
        step(8);
        nvec++;
        if (seg !== 8'h71 || sel !== 3'd5) begin
            nerr++;
            $display("FAIL live_dig5 got seg=%h sel=%0d exp 71/5", seg, sel);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_scan_en();
        test_live_update();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
